// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector run controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_PAT_W   = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TO_W    = 16;
  localparam int RST_TARGET  = 1;
  localparam int RST_TIMEOUT = 0;

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register, fill counter and pattern compare.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  history;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  next_hist;

  assign next_hist = {history[PAT_W-2:0], din};

  // fill >= PAT_W-1 means this bit completes a full window of real samples
  assign match = en && (next_hist == pattern) && (fill >= FILL_W'(PAT_W - 1));

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      history <= '0;
      fill    <= '0;
    end else if (en) begin
      history <= next_hist;
      if (fill != FILL_W'(PAT_W)) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config registers, run FSM, hit counter and timeout counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TO_W  = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done,
  output logic             timeout_flag
);

  state_t           state;
  logic [PAT_W-1:0] pattern_q;
  logic [CNT_W-1:0] target_q;
  logic [TO_W-1:0]  timeout_q;
  logic [TO_W-1:0]  to_cnt;
  logic             match;
  logic             core_clr;
  logic             core_en;
  logic             tgt_hit;
  logic             to_hit;

  assign cfg_ready = (state == S_IDLE);
  assign core_clr  = (state == S_IDLE) && start && !abort;
  assign core_en   = (state == S_RUN) && din_valid && !abort;
  assign tgt_hit   = match && (target_q != '0) && (hit_count + CNT_W'(1) == target_q);
  assign to_hit    = (timeout_q != '0) && (to_cnt == timeout_q - TO_W'(1));

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (core_clr),
    .en      (core_en),
    .din     (din),
    .pattern (pattern_q),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      pattern_q    <= '0;
      target_q     <= CNT_W'(RST_TARGET);
      timeout_q    <= TO_W'(RST_TIMEOUT);
      to_cnt       <= '0;
      hit          <= 1'b0;
      hit_count    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      hit   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            pattern_q <= cfg_pattern;
            target_q  <= cfg_target;
            timeout_q <= cfg_timeout;
          end
          if (start) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            hit_count    <= '0;
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
          end
        end
        S_RUN: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (match) begin
            hit <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end
          // target completion outranks a timeout landing on the same edge
          if (tgt_hit) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            timeout_flag <= 1'b0;
          end else if (to_hit) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            timeout_flag <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
